// File: rtl/sobel_edge_packer.sv
// sobel_edge_packer
// Packs the Sobel pixel stream into 1-bit-per-pixel words and buffers them for
// a valid/ready consumer, with frame/line flags and a per-frame edge count.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   valid_s, ready_s     pixel handshake (ready_s = FIFO not full)
//   data_s_sobel [23:0]  Sobel pixel, nonzero means edge
//   valid_m, ready_m     packed word handshake (FIFO head, first-word-fall-through)
//   data_m_word [WORD_W] packed edge bits, pixel k of a word at bit k
//   sof_m/eol_m/eof_m    first word of frame / last word of line / last word of frame
//   edge_count [CNT_W]   edge pixels in the last completed frame
//   frame_done           one-cycle pulse when edge_count updates
module sobel_edge_packer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_s,
    input  logic [23:0]       data_s_sobel,
    output logic              ready_s,
    output logic              valid_m,
    input  logic              ready_m,
    output logic [WORD_W-1:0] data_m_word,
    output logic              sof_m,
    output logic              eol_m,
    output logic              eof_m,
    output logic [CNT_W-1:0]  edge_count,
    output logic              frame_done
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BIT_W = (WORD_W     > 1) ? $clog2(WORD_W)     : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = WORD_W + 3;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] pack;
    logic [CNT_W-1:0]  running;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    logic              full, empty, accept, push, pop, edge_bit;
    logic              last_col, last_row, last_bit, first_word;
    logic [WORD_W-1:0] word_next;
    logic [ENT_W-1:0]  entry, head;

    assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign ready_s  = !full;
    assign accept   = valid_s && ready_s;
    assign pop      = !empty && ready_m;
    assign edge_bit = |data_s_sobel;

    assign last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
    assign last_bit = (bit_idx == BIT_W'(WORD_W - 1));
    // Words restart at column 0 of every line, so the first word of a line is
    // the one that closes before column WORD_W.
    assign first_word = (int'(col) < WORD_W);

    assign word_next = pack | (WORD_W'(edge_bit) << bit_idx);
    assign push      = accept && (last_bit || last_col);
    assign entry     = {word_next, (row == '0) && first_word, last_col, last_col && last_row};

    // Gate the head so stale RAM contents never show while empty (and after reset).
    assign head        = empty ? '0 : mem[rd_ptr];
    assign valid_m     = !empty;
    assign data_m_word = head[ENT_W-1:3];
    assign sof_m       = head[2];
    assign eol_m       = head[1];
    assign eof_m       = head[0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            bit_idx    <= '0;
            pack       <= '0;
            running    <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (push) begin
                    bit_idx <= '0;
                    pack    <= '0;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                    pack    <= word_next;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (last_col && last_row) begin
                    edge_count <= running + CNT_W'(edge_bit);
                    running    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    running <= running + CNT_W'(edge_bit);
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
